// File: rtl/adc_spi_master.sv
// SPI master for a 10-bit MCP300x-style ADC. It runs periodic conversions from an
// internal trigger timer and shifts 16-clock frames.
// Optional build macro ADC_OVERSAMPLE_EN: each trigger runs 4 frames and reports
// the average of the 4 results.
module adc_spi_master #(
  parameter int unsigned CLK_DIV       = 20,
  parameter int unsigned SAMPLE_PERIOD = 40000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       channel,
  output logic       adc_cs_n,
  output logic       adc_sck,
  output logic       adc_mosi,
  input  logic       adc_miso,
  output logic [9:0] sample,
  output logic       sample_valid,
  output logic       busy,
  output logic       overrun
);

  localparam int unsigned TMR_W = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam int unsigned DIV_W = $clog2(2 * CLK_DIV);

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_e;

  state_e             state_q, state_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [3:0]         bit_q, bit_d;
  logic               chan_q, chan_d;
  logic               cs_n_q, cs_n_d;
  logic               sck_q, sck_d;
  logic               mosi_q, mosi_d;
  logic [9:0]         shreg_q, shreg_d;
  logic [9:0]         sample_q, sample_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;
  logic               overrun_q, overrun_d;
  logic               trigger_c;
  logic               half_done_c;
`ifdef ADC_OVERSAMPLE_EN
  logic [1:0]         frame_q, frame_d;
  logic [11:0]        sum_q, sum_d;
  logic [11:0]        sum_nx;
`endif

  // Command bit for frame position idx: 0, start, SGL, ODD=channel, MSBF, then zeros.
  function automatic logic frame_bit(input logic [3:0] idx, input logic ch);
    case (idx)
      4'd1, 4'd2, 4'd4: frame_bit = 1'b1;
      4'd3:             frame_bit = ch;
      default:          frame_bit = 1'b0;
    endcase
  endfunction

  // Trigger timer: free-runs while enabled, fires at the wrap.
  always_comb begin
    trigger_c = enable && (tmr_q == TMR_W'(SAMPLE_PERIOD - 1));
    if (!enable || trigger_c) tmr_d = '0;
    else                      tmr_d = tmr_q + TMR_W'(1);
  end

  // Frame sequencer: next state and all registered outputs.
  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    bit_d       = bit_q;
    chan_d      = chan_q;
    cs_n_d      = cs_n_q;
    sck_d       = sck_q;
    mosi_d      = mosi_q;
    shreg_d     = shreg_q;
    sample_d    = sample_q;
    valid_d     = 1'b0;
    busy_d      = busy_q;
    overrun_d   = overrun_q;
    half_done_c = (div_q == DIV_W'(CLK_DIV - 1));
`ifdef ADC_OVERSAMPLE_EN
    frame_d     = frame_q;
    sum_d       = sum_q;
    sum_nx      = sum_q + 12'(shreg_q);
`endif

    if (trigger_c && (state_q != IDLE)) overrun_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (trigger_c) begin
          chan_d  = channel;
          cs_n_d  = 1'b0;
          sck_d   = 1'b0;
          mosi_d  = 1'b0;
          div_d   = '0;
          bit_d   = '0;
          busy_d  = 1'b1;
          state_d = SETUP;
`ifdef ADC_OVERSAMPLE_EN
          frame_d = '0;
          sum_d   = '0;
`endif
        end
      end
      SETUP: begin
        if (half_done_c) begin
          div_d   = '0;
          sck_d   = 1'b1;
          shreg_d = {shreg_q[8:0], adc_miso};
          state_d = SHIFT;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      SHIFT: begin
        if (half_done_c) begin
          div_d = '0;
          if (sck_q) begin
            sck_d = 1'b0;
            if (bit_q == 4'd15) begin
              cs_n_d  = 1'b1;
              mosi_d  = 1'b0;
              state_d = HOLD;
`ifdef ADC_OVERSAMPLE_EN
              frame_d = frame_q + 2'd1;
              sum_d   = sum_nx;
              if (frame_q == 2'd3) begin
                sample_d = 10'(sum_nx >> 2);
                valid_d  = 1'b1;
              end
`else
              sample_d = shreg_q;
              valid_d  = 1'b1;
`endif
            end else begin
              bit_d  = bit_q + 4'd1;
              mosi_d = frame_bit(4'(bit_q + 4'd1), chan_q);
            end
          end else begin
            sck_d   = 1'b1;
            shreg_d = {shreg_q[8:0], adc_miso};
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      HOLD: begin
        if (div_q == DIV_W'(2 * CLK_DIV - 1)) begin
          div_d = '0;
`ifdef ADC_OVERSAMPLE_EN
          if (frame_q != 2'd0) begin
            cs_n_d  = 1'b0;
            mosi_d  = 1'b0;
            bit_d   = '0;
            state_d = SETUP;
          end else begin
            busy_d  = 1'b0;
            state_d = IDLE;
          end
`else
          busy_d  = 1'b0;
          state_d = IDLE;
`endif
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      tmr_q     <= '0;
      div_q     <= '0;
      bit_q     <= '0;
      chan_q    <= 1'b0;
      cs_n_q    <= 1'b1;
      sck_q     <= 1'b0;
      mosi_q    <= 1'b0;
      shreg_q   <= '0;
      sample_q  <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
`ifdef ADC_OVERSAMPLE_EN
      frame_q   <= '0;
      sum_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      tmr_q     <= tmr_d;
      div_q     <= div_d;
      bit_q     <= bit_d;
      chan_q    <= chan_d;
      cs_n_q    <= cs_n_d;
      sck_q     <= sck_d;
      mosi_q    <= mosi_d;
      shreg_q   <= shreg_d;
      sample_q  <= sample_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      overrun_q <= overrun_d;
`ifdef ADC_OVERSAMPLE_EN
      frame_q   <= frame_d;
      sum_q     <= sum_d;
`endif
    end
  end

  assign adc_cs_n     = cs_n_q;
  assign adc_sck      = sck_q;
  assign adc_mosi     = mosi_q;
  assign sample       = sample_q;
  assign sample_valid = valid_q;
  assign busy         = busy_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_adc_spi_master.sv
// Directed bench for adc_spi_master: DUT a (period 200) checks frames, DUT b (period 60) checks overrun.
module tb_adc_spi_master;

  logic       clk;
  logic       rst_a, rst_b;
  logic       enable_a, enable_b;
  logic       channel_a, channel_b;
  logic       cs_n_a, sck_a, mosi_a, miso_a;
  logic       cs_n_b, sck_b, mosi_b, miso_b;
  logic [9:0] sample_a, sample_b;
  logic       valid_a, valid_b;
  logic       busy_a, busy_b;
  logic       overrun_a, overrun_b;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // ADC model state for DUT a
  logic [9:0]  adc_val = '0;
  logic        adc_inc = 1'b0;
  int          inc_base = 0;
  logic [9:0]  cur_a = '0;
  int          idx_a = 0;
  logic        cs_prev_a = 1'b1, sck_prev_a = 1'b0;
  int          cs_falls_a = 0, cs_cyc_a = 0, valid_cnt_a = 0, last_lat_a = 0;
  logic [15:0] mosi_cap_a = '0, last_mosi_a = '0;
  logic        last_cs_a = 1'b0;
  int          valid_cnt_b = 0;

  adc_spi_master #(.CLK_DIV(2), .SAMPLE_PERIOD(200)) dut_a (
    .clk(clk), .reset(rst_a), .enable(enable_a), .channel(channel_a),
    .adc_cs_n(cs_n_a), .adc_sck(sck_a), .adc_mosi(mosi_a), .adc_miso(miso_a),
    .sample(sample_a), .sample_valid(valid_a), .busy(busy_a), .overrun(overrun_a));

  adc_spi_master #(.CLK_DIV(2), .SAMPLE_PERIOD(60)) dut_b (
    .clk(clk), .reset(rst_b), .enable(enable_b), .channel(channel_b),
    .adc_cs_n(cs_n_b), .adc_sck(sck_b), .adc_mosi(mosi_b), .adc_miso(miso_b),
    .sample(sample_b), .sample_valid(valid_b), .busy(busy_b), .overrun(overrun_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign miso_b = 1'b0;

  // ADC slave model: tracks bit position, serves result MSB-first, captures MOSI at sck rise.
  always @(negedge clk) begin
    logic [15:0] word;
    if (cs_prev_a && !cs_n_a) begin
      idx_a      = 0;
      cur_a      = adc_inc ? 10'(adc_val + 10'(cs_falls_a - inc_base)) : adc_val;
      cs_falls_a = cs_falls_a + 1;
      cs_cyc_a   = cyc;
      mosi_cap_a = '0;
    end else if (sck_prev_a && !sck_a) begin
      idx_a = idx_a + 1;
    end
    if (!sck_prev_a && sck_a && idx_a < 16) mosi_cap_a[4'(idx_a)] = mosi_a;
    if (valid_a) begin
      valid_cnt_a = valid_cnt_a + 1;
      last_mosi_a = mosi_cap_a;
      last_lat_a  = cyc - cs_cyc_a;
      last_cs_a   = cs_n_a;
    end
    if (valid_b) valid_cnt_b = valid_cnt_b + 1;
    word   = {6'b0, cur_a};
    miso_a = (idx_a >= 6 && idx_a < 16) ? word[4'(15 - idx_a)] : 1'b0;
    cs_prev_a  = cs_n_a;
    sck_prev_a = sck_a;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_valid_a(input int n0, input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound && !ok; i++) begin
      tick();
      if (valid_cnt_a > n0) ok = 1'b1;
    end
  endtask

  task automatic wait_cs_a(input int n0, input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound && !ok; i++) begin
      tick();
      if (cs_falls_a > n0) ok = 1'b1;
    end
  endtask

  typedef struct {
    logic        ch;
    logic [9:0]  val;
    logic [15:0] exp_mosi;
    logic [9:0]  exp_sample;
  } vec_t;

  initial begin
    vec_t vecs[4];
    bit   ok;
    int   n0, f0;

    vecs[0] = '{1'b1, 10'h2A5, 16'h001E, 10'h2A5};
    vecs[1] = '{1'b0, 10'h3FF, 16'h0016, 10'h3FF};
    vecs[2] = '{1'b1, 10'h000, 16'h001E, 10'h000};
    vecs[3] = '{1'b0, 10'h155, 16'h0016, 10'h155};

    rst_a = 1'b1; rst_b = 1'b1;
    enable_a = 1'b0; enable_b = 1'b0;
    channel_a = 1'b0; channel_b = 1'b0;
    repeat (3) tick();
    check("rst_cs_n", 32'(cs_n_a), 1);
    check("rst_sck", 32'(sck_a), 0);
    check("rst_mosi", 32'(mosi_a), 0);
    check("rst_sample", 32'(sample_a), 0);
    check("rst_valid", 32'(valid_a), 0);
    check("rst_busy", 32'(busy_a), 0);
    check("rst_overrun", 32'(overrun_a), 0);
    rst_a = 1'b0; rst_b = 1'b0;
    tick();

`ifndef ADC_OVERSAMPLE_EN
    // Table-driven single frames
    enable_a = 1'b1;
    for (int i = 0; i < 4; i++) begin
      channel_a = vecs[i].ch;
      adc_val   = vecs[i].val;
      n0 = valid_cnt_a;
      wait_valid_a(n0, 400, ok);
      check("vec_timeout", 32'(ok), 1);
      check("vec_sample", 32'(sample_a), 32'(vecs[i].exp_sample));
      check("vec_mosi", 32'(last_mosi_a), 32'(vecs[i].exp_mosi));
      check("vec_latency", 32'(last_lat_a), 64);
      check("vec_cs_high", 32'(last_cs_a), 1);
      check("vec_one_pulse", 32'(valid_cnt_a), 32'(n0 + 1));
    end
    check("no_overrun_a", 32'(overrun_a), 0);

    // Channel change mid-frame only affects the next frame
    channel_a = 1'b0;
    wait_cs_a(cs_falls_a, 300, ok);
    check("ch_cs_timeout", 32'(ok), 1);
    repeat (20) tick();
    channel_a = 1'b1;
    wait_valid_a(valid_cnt_a, 200, ok);
    check("ch_cur_frame", 32'(last_mosi_a), 32'h0016);
    wait_valid_a(valid_cnt_a, 300, ok);
    check("ch_next_timeout", 32'(ok), 1);
    check("ch_next_frame", 32'(last_mosi_a), 32'h001E);

    // Enable dropped at bit 4: frame completes, no further frames
    wait_cs_a(cs_falls_a, 300, ok);
    check("en_cs_timeout", 32'(ok), 1);
    repeat (18) tick();
    enable_a = 1'b0;
    n0 = valid_cnt_a;
    wait_valid_a(n0, 200, ok);
    check("en_frame_done", 32'(ok), 1);
    n0 = valid_cnt_a;
    f0 = cs_falls_a;
    repeat (450) tick();
    check("en_no_cs", 32'(cs_falls_a), 32'(f0));
    check("en_no_valid", 32'(valid_cnt_a), 32'(n0));
    check("en_busy_low", 32'(busy_a), 0);

    // Asynchronous reset at bit 8
    enable_a = 1'b1;
    wait_cs_a(cs_falls_a, 300, ok);
    check("rs_cs_timeout", 32'(ok), 1);
    repeat (34) tick();
    check("rs_sck_high", 32'(sck_a), 1);
    n0 = valid_cnt_a;
    #2;
    rst_a = 1'b1;
    #1;
    check("rs_cs_async", 32'(cs_n_a), 1);
    check("rs_sck_async", 32'(sck_a), 0);
    repeat (5) tick();
    check("rs_no_valid", 32'(valid_cnt_a), 32'(n0));
    check("rs_sample", 32'(sample_a), 0);
    check("rs_busy", 32'(busy_a), 0);
    enable_a = 1'b0;
    rst_a = 1'b0;
    tick();

    // Overrun on a short sample period, sampling continues
    enable_b = 1'b1;
    tick();
    check("ov_initial", 32'(overrun_b), 0);
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      tick();
      if (overrun_b) ok = 1'b1;
    end
    check("ov_set", 32'(ok), 1);
    n0 = valid_cnt_b;
    repeat (200) tick();
    check("ov_continues", 32'(valid_cnt_b > n0), 1);
    check("ov_sticky", 32'(overrun_b), 1);
`else
    // Oversampling: 4 frames per trigger, averaged
    adc_val  = 10'd100;
    adc_inc  = 1'b1;
    inc_base = cs_falls_a;
    f0 = cs_falls_a;
    n0 = valid_cnt_a;
    enable_a = 1'b1;
    wait_valid_a(n0, 800, ok);
    check("os_timeout", 32'(ok), 1);
    check("os_cs_falls", 32'(cs_falls_a - f0), 4);
    check("os_sample", 32'(sample_a), 101);
    check("os_one_pulse", 32'(valid_cnt_a), 32'(n0 + 1));
    check("os_busy_hold", 32'(busy_a), 1);
    repeat (10) tick();
    check("os_busy_low", 32'(busy_a), 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/adc_spi_master.md
ADC_SPI_MASTER -- requirements
Module: adc_spi_master

Interface
REQ-001 SHALL have parameter CLK_DIV, default 20, meaning clk cycles per sck half-period (min 2).
REQ-002 SHALL have parameter SAMPLE_PERIOD, default 40000, meaning clk cycles between conversion triggers (min 64*CLK_DIV).
REQ-003 SHALL have port clk  input  1  system clock; all logic is on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port enable  input  1  allows periodic conversions.
REQ-006 SHALL have port channel  input  1  ADC input channel select (ODD bit).
REQ-007 SHALL have port adc_cs_n  output  1  ADC chip select, active-low.
REQ-008 SHALL have port adc_sck  output  1  serial clock to the ADC; idle low.
REQ-009 SHALL have port adc_mosi  output  1  command bit to the ADC.
REQ-010 SHALL have port adc_miso  input  1  data bit from the ADC.
REQ-011 SHALL have port sample  output  10  last completed conversion result.
REQ-012 SHALL have port sample_valid  output  1  one-clk pulse when sample updates.
REQ-013 SHALL have port busy  output  1  high from frame start until the HOLD state ends.
REQ-014 SHALL have port overrun  output  1  sticky flag: a trigger arrived while busy.

Function
REQ-015 SHALL implement states IDLE -> SETUP -> SHIFT -> HOLD -> IDLE.
REQ-016 Trigger timer SHALL count 0..SAMPLE_PERIOD-1 while enable=1, wrap to 0, emit trigger at the wrap, and be held at 0 while enable=0.
REQ-017 Trigger in IDLE SHALL latch channel, assert adc_cs_n=0 on the next clk, and enter SETUP.
REQ-018 Trigger outside IDLE SHALL be dropped and set overrun=1.
REQ-019 SETUP SHALL last CLK_DIV clks; first adc_sck rising edge SHALL occur at its end.
REQ-020 A frame SHALL have exactly 16 adc_sck periods, each 2*CLK_DIV clks, 50% duty.
REQ-021 adc_mosi SHALL present frame bits 0..15 = 0, 1(start), 1(SGL), channel, 1(MSBF), then 0 x11.
REQ-022 Bit 0 SHALL be driven at the CS fall; each later bit SHALL change only on an adc_sck falling edge.
REQ-023 adc_miso SHALL be sampled on the clk that raises adc_sck; bits 6..15 SHALL form D9..D0, MSB first.
REQ-024 On the 16th falling edge, adc_cs_n SHALL go high, sample SHALL update, and sample_valid SHALL pulse for 1 clk, all in the same cycle (32*CLK_DIV clks after CS fall).
REQ-025 HOLD SHALL keep adc_cs_n=1 for 2*CLK_DIV clks; busy SHALL drop on the HOLD->IDLE transition.
REQ-026 enable falling mid-frame SHALL NOT abort the frame.
REQ-027 channel changes mid-frame SHALL have no effect until the next frame.
REQ-028 adc_sck SHALL be low whenever adc_cs_n=1.

Reset
REQ-029 Reset SHALL force IDLE, adc_cs_n=1, adc_sck=0, adc_mosi=0, sample=0, sample_valid=0, busy=0, overrun=0, and trigger timer=0.
REQ-030 Reset asserted mid-frame SHALL abort the frame immediately without a sample_valid pulse.

Configuration
REQ-031 With macro ADC_OVERSAMPLE_EN defined:
- each trigger SHALL run 4 back-to-back frames, each separated by HOLD;
- results SHALL accumulate in a 12-bit sum;
- sample SHALL be sum>>2, with a single sample_valid pulse after the 4th frame;
- busy SHALL stay high across all 4 frames.
REQ-032 Without ADC_OVERSAMPLE_EN, each trigger SHALL run one frame and sample SHALL be the raw result.

Verification (CLK_DIV=2, SAMPLE_PERIOD=200, macro off unless stated)
REQ-033 Stimulus: enable=1, channel=1, ADC model returns 10'h2A5. Response: MOSI bits 0,1,1,1,1,0..., sample=10'h2A5, sample_valid pulses 64 clks after CS fall.
REQ-034 Stimulus: channel toggles 0->1 mid-frame. Response: the current frame's bit 3 = 0; the next frame's bit 3 = 1.
REQ-035 Stimulus: SAMPLE_PERIOD=60. Response: overrun=1 after the second trigger; sampling continues.
REQ-036 Stimulus: reset at SHIFT bit 8. Response: adc_cs_n=1 and adc_sck=0 asynchronously; no sample_valid; sample=0.
REQ-037 Stimulus: enable dropped at bit 4. Response: the frame completes with one sample_valid; no further CS falls.
REQ-038 Stimulus: ADC_OVERSAMPLE_EN defined, results 100, 101, 102, 103. Response: 4 CS falls, then sample=101 with a single sample_valid pulse.
